gemm_tile_sequencer: RTL and testbench

//  Controller that sequences one GEMM tile through the fixed-weight systolic GEMM datapath.

---
 rtl/gemm_tile_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_sequencer.sv
// -----------------------------------------------------------------------------
// gemm_tile_sequencer
//
// Purpose
//   Sequences one GEMM tile through a fixed-weight systolic datapath:
//     1. optionally load SA_SIZE weight rows (valid/ready),
//     2. stream num_rows activation rows (valid/ready),
//     3. drain the array with zero bubbles until every real row has emerged.
//   The sequencer owns the datapath's advance strobe and keeps its own
//   LAT-deep tag pipe, which says whether the row leaving the array is a real
//   result or a bubble. The datapath's own output_valid is not consulted.
//
// Ports
//   clk_i            clock
//   reset_i          synchronous active-high reset (aborts any tile in flight)
//   start_i          begin a tile; only looked at while idle
//   load_weights_i   with start_i: 1 = load weights first, 0 = reuse resident ones
//   num_rows_i       activation rows in the tile, captured on an accepted start
//   busy_o           high whenever the sequencer is not idle
//   done_o           one-cycle pulse at the end of the tile
//   w_valid_i        weight row available
//   w_ready_o        sequencer accepts weight rows (weight-load phase)
//   w_load_o         weight row w_row_idx_o is written this cycle
//   w_row_idx_o      index of the weight row being loaded
//   in_valid_i       activation row available
//   in_ready_o       activation row consumed this cycle when in_valid_i is high
//   sa_advance_o     datapath advance (should_advance_computation)
//   sa_bubble_o      datapath feeds zeros into the array on this advance
//   out_valid_o      row at the datapath output is a real result
//   out_ready_i      result sink accepts the row
//   out_last_o       out_valid_o for the final row of the tile
// -----------------------------------------------------------------------------
module gemm_tile_sequencer #(
  parameter int SA_SIZE = 4,
  parameter int ROW_W   = 16,
  localparam int IDX_W  = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             load_weights_i,
  input  logic [ROW_W-1:0] num_rows_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             w_valid_i,
  output logic             w_ready_o,
  output logic             w_load_o,
  output logic [IDX_W-1:0] w_row_idx_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             sa_advance_o,
  output logic             sa_bubble_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o
);

  // Advances from a row entering the array to its result at the output.
  localparam int LAT = 2 * SA_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] num_rows_q, num_rows_d;
  logic [ROW_W-1:0] issued_q, issued_d;
  logic [ROW_W-1:0] emitted_q, emitted_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [LAT-1:0]   tag_q, tag_d;

  logic out_valid_s;
  logic can_move_s;
  logic xfer_s;
  logic start_ok_s;
  logic last_w_s;
  logic rows_left_s;
  logic w_ready_s;
  logic w_load_s;
  logic in_ready_s;
  logic real_adv_s;
  logic sa_advance_s;
  logic sa_bubble_s;

  // The oldest tag slot corresponds to the row currently at the datapath output.
  assign out_valid_s = tag_q[LAT-1];

  // The whole array is one stall domain: nothing moves while a real result
  // sits at the output unaccepted, otherwise that result would be overwritten.
  assign can_move_s  = ~out_valid_s | out_ready_i;
  assign xfer_s      = out_valid_s & out_ready_i;
  assign start_ok_s  = (state_q == ST_IDLE) & start_i;
  assign last_w_s    = (w_idx_q == IDX_W'(SA_SIZE - 1));
  assign rows_left_s = (issued_q < num_rows_q);

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = load_weights_i ? ST_LOAD_W : ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (w_load_s & last_w_s) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_LOAD_W;
        end
      end
      ST_STREAM: begin
        // Leave as soon as the final row is consumed (issued_d already counts
        // it), so a tile of zero rows falls straight through to DRAIN.
        if (issued_d == num_rows_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        // Finish on the advance that pushes the last real row out.
        if (tag_d == {LAT{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and datapath-control outputs decoded from the current state.
  always_comb begin
    w_ready_s    = 1'b0;
    w_load_s     = 1'b0;
    in_ready_s   = 1'b0;
    real_adv_s   = 1'b0;
    sa_advance_s = 1'b0;
    sa_bubble_s  = 1'b0;
    case (state_q)
      ST_LOAD_W: begin
        w_ready_s = 1'b1;
        w_load_s  = w_valid_i;
      end
      ST_STREAM: begin
        in_ready_s = can_move_s & rows_left_s;
        real_adv_s = in_ready_s & in_valid_i;
        if (real_adv_s) begin
          sa_advance_s = 1'b1;
          sa_bubble_s  = 1'b0;
        end else if (xfer_s) begin
          // No input row but a result is leaving: shift in a bubble so the
          // accepted result is not presented again.
          sa_advance_s = 1'b1;
          sa_bubble_s  = 1'b1;
        end else begin
          sa_advance_s = 1'b0;
          sa_bubble_s  = 1'b0;
        end
      end
      ST_DRAIN: begin
        sa_advance_s = can_move_s & (|tag_q);
        sa_bubble_s  = 1'b1;
      end
      default: begin
        w_ready_s    = 1'b0;
        w_load_s     = 1'b0;
        in_ready_s   = 1'b0;
        real_adv_s   = 1'b0;
        sa_advance_s = 1'b0;
        sa_bubble_s  = 1'b0;
      end
    endcase
  end

  // Next values for the tile counters, weight index and tag pipe.
  always_comb begin
    num_rows_d = num_rows_q;
    issued_d   = issued_q;
    emitted_d  = emitted_q;
    w_idx_d    = w_idx_q;
    tag_d      = tag_q;
    if (start_ok_s) begin
      num_rows_d = num_rows_i;
      issued_d   = {ROW_W{1'b0}};
      emitted_d  = {ROW_W{1'b0}};
      w_idx_d    = {IDX_W{1'b0}};
      tag_d      = {LAT{1'b0}};
    end else begin
      if (real_adv_s) begin
        issued_d = issued_q + ROW_W'(1);
      end else begin
        issued_d = issued_q;
      end
      if (xfer_s) begin
        emitted_d = emitted_q + ROW_W'(1);
      end else begin
        emitted_d = emitted_q;
      end
      // Explicit return to zero after the last row keeps the index correct
      // for array sizes that are not a power of two.
      if (w_load_s) begin
        w_idx_d = last_w_s ? {IDX_W{1'b0}} : (w_idx_q + IDX_W'(1));
      end else begin
        w_idx_d = w_idx_q;
      end
      // The tag pipe moves in lockstep with the array: 1 marks a real row.
      if (sa_advance_s) begin
        tag_d = {tag_q[LAT-2:0], ~sa_bubble_s};
      end else begin
        tag_d = tag_q;
      end
    end
  end

  // Tile counters, weight index and tag pipe registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      num_rows_q <= {ROW_W{1'b0}};
      issued_q   <= {ROW_W{1'b0}};
      emitted_q  <= {ROW_W{1'b0}};
      w_idx_q    <= {IDX_W{1'b0}};
      tag_q      <= {LAT{1'b0}};
    end else begin
      num_rows_q <= num_rows_d;
      issued_q   <= issued_d;
      emitted_q  <= emitted_d;
      w_idx_q    <= w_idx_d;
      tag_q      <= tag_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign w_ready_o    = w_ready_s;
  assign w_load_o     = w_load_s;
  assign w_row_idx_o  = w_idx_q;
  assign in_ready_o   = in_ready_s;
  assign sa_advance_o = sa_advance_s;
  assign sa_bubble_o  = sa_bubble_s;
  assign out_valid_o  = out_valid_s;
  // num_rows_q - 1 wraps for an empty tile, but out_valid is never set then.
  assign out_last_o   = out_valid_s & (emitted_q == (num_rows_q - ROW_W'(1)));

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Testbench for gemm_tile_sequencer (SA_SIZE=4, LAT=8).
// Every cycle the DUT outputs are compared with a reference model that treats
// the array as a queue of in-flight real rows, each stamped with the advance
// count at which it entered; a row is at the output once LAT advances have
// happened since its entry.
module tb_gemm_tile_sequencer;
  localparam int SA  = 4;
  localparam int RW  = 16;
  localparam int LAT = 2 * SA;

  localparam int P_IDLE   = 0;
  localparam int P_LOADW  = 1;
  localparam int P_STREAM = 2;
  localparam int P_DRAIN  = 3;
  localparam int P_DONE   = 4;

  logic          clk;
  logic          reset, start, load_weights, w_valid, in_valid, out_ready;
  logic [RW-1:0] num_rows;
  logic          busy, done, w_ready, w_load, in_ready;
  logic          sa_advance, sa_bubble, out_valid, out_last;
  logic [1:0]    w_row_idx;

  gemm_tile_sequencer #(.SA_SIZE(SA), .ROW_W(RW)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .load_weights_i (load_weights),
    .num_rows_i     (num_rows),
    .busy_o         (busy),
    .done_o         (done),
    .w_valid_i      (w_valid),
    .w_ready_o      (w_ready),
    .w_load_o       (w_load),
    .w_row_idx_o    (w_row_idx),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .sa_advance_o   (sa_advance),
    .sa_bubble_o    (sa_bubble),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_last_o     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-tile tallies of observed DUT activity.
  int c_wload, c_xfer, c_last, c_adv, c_inrdy, c_done, c_sbub;

  // Reference model state.
  int m_phase, m_n, m_issued, m_emitted, m_widx, m_adv;
  int m_q[$];

  // Model expectations for the current cycle.
  logic       e_busy, e_done, e_wready, e_wload, e_inready, e_adv, e_bub, e_ov, e_last;
  logic       e_real, e_xfer;
  logic [1:0] e_idx;

  typedef struct {
    logic lw;
    int   n;
    int   exp_cycles;
    int   exp_xfer;
    int   exp_last;
    int   exp_adv;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase   = P_IDLE;
    m_n       = 0;
    m_issued  = 0;
    m_emitted = 0;
    m_widx    = 0;
    m_adv     = 0;
    m_q.delete();
  endfunction

  function automatic void clear_tallies();
    c_wload = 0; c_xfer = 0; c_last = 0; c_adv = 0;
    c_inrdy = 0; c_done = 0; c_sbub = 0;
  endfunction

  function automatic void model_eval();
    logic can;
    e_ov = 1'b0;
    if (m_q.size() > 0) e_ov = ((m_adv - m_q[0]) == LAT);
    can       = !e_ov || out_ready;
    e_busy    = (m_phase != P_IDLE);
    e_done    = (m_phase == P_DONE);
    e_wready  = (m_phase == P_LOADW);
    e_wload   = e_wready && w_valid;
    e_idx     = 2'(m_widx);
    e_inready = (m_phase == P_STREAM) && can && (m_issued < m_n);
    e_real    = e_inready && in_valid;
    e_xfer    = e_ov && out_ready;
    if (m_phase == P_STREAM)     e_adv = e_real || e_xfer;
    else if (m_phase == P_DRAIN) e_adv = can && (m_q.size() > 0);
    else                         e_adv = 1'b0;
    e_bub  = e_adv && !e_real;
    e_last = e_ov && (m_emitted == m_n - 1);
  endfunction

  function automatic void model_step();
    if (reset) begin
      model_reset();
      return;
    end
    if (e_adv) begin
      if (e_real) m_q.push_back(m_adv);
      m_adv++;
    end
    if (e_xfer) begin
      void'(m_q.pop_front());
      m_emitted++;
    end
    case (m_phase)
      P_IDLE: if (start) begin
        m_n       = int'(num_rows);
        m_issued  = 0;
        m_emitted = 0;
        m_phase   = load_weights ? P_LOADW : P_STREAM;
      end
      P_LOADW: if (e_wload) begin
        if (m_widx == SA - 1) begin
          m_widx  = 0;
          m_phase = P_STREAM;
        end else begin
          m_widx++;
        end
      end
      P_STREAM: begin
        if (e_real) m_issued++;
        if (m_issued == m_n) m_phase = P_DRAIN;
      end
      P_DRAIN: if (m_q.size() == 0) m_phase = P_DONE;
      P_DONE:  m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endfunction

  // One clock: inputs are set by the caller just after a falling edge.
  task automatic cycle();
    logic [10:0] act, exp;
    #1;
    model_eval();
    act = {busy, done, w_ready, w_load, w_row_idx, in_ready, sa_advance,
           sa_bubble & sa_advance, out_valid, out_last};
    exp = {e_busy, e_done, e_wready, e_wload, e_idx, e_inready, e_adv,
           e_bub, e_ov, e_last};
    check("cycle_outputs", 32'(act), 32'(exp));
    if (w_load) c_wload++;
    if (out_valid && out_ready) c_xfer++;
    if (out_last && out_ready) c_last++;
    if (sa_advance) c_adv++;
    if (in_ready) c_inrdy++;
    if (done) c_done++;
    if (sa_advance && sa_bubble && in_ready) c_sbub++;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic start_tile(input logic lw, input int n);
    clear_tallies();
    start        = 1'b1;
    load_weights = lw;
    num_rows     = RW'(n);
    cycle();
    start        = 1'b0;
    load_weights = ~lw;
    num_rows     = RW'(n + 7);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (c_done == 0 && cyc < budget) begin
      cyc++;
      cycle();
    end
    check("done_pulse_once", c_done, 1);
  endtask

  initial begin
    int   cyc;
    int   k;
    vec_t vecs[6];

    vecs[0] = '{1'b1, 3,  16, 3,  1, 11};
    vecs[1] = '{1'b0, 0,  3,  0,  0, 0};
    vecs[2] = '{1'b1, 0,  7,  0,  0, 0};
    vecs[3] = '{1'b0, 1,  10, 1,  1, 9};
    vecs[4] = '{1'b0, 12, 21, 12, 1, 20};
    vecs[5] = '{1'b1, 7,  20, 7,  1, 15};

    reset = 1'b1; start = 1'b0; load_weights = 1'b0; num_rows = '0;
    w_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear_tallies();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    #1;
    check("reset_outputs", {busy, done, w_ready, w_load, w_row_idx, in_ready,
                            sa_advance, out_valid, out_last}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table: free-flowing tiles, all valids/readies held high.
    for (int i = 0; i < 6; i++) begin
      w_valid = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      start_tile(vecs[i].lw, vecs[i].n);
      wait_done(200, cyc);
      check("tile_cycles",   cyc,     vecs[i].exp_cycles);
      check("tile_xfers",    c_xfer,  vecs[i].exp_xfer);
      check("tile_last",     c_last,  vecs[i].exp_last);
      check("tile_adv",      c_adv,   vecs[i].exp_adv);
      check("tile_in_ready", c_inrdy, vecs[i].n);
      check("tile_wload",    c_wload, vecs[i].lw ? SA : 0);
      check("busy_after_done", busy, 1'b0);
    end

    // Output stall: hold out_ready low for 6 cycles at the first result.
    w_valid = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    start_tile(1'b0, 5);
    k = 0;
    while (!out_valid && k < 40) begin cycle(); k++; end
    check("stall_reached", out_valid, 1'b1);
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cycle();
      check("stall_frozen", {sa_advance, in_ready, out_valid}, 3'b001);
    end
    out_ready = 1'b1;
    wait_done(100, cyc);
    check("stall_xfers", c_xfer, 5);
    check("stall_last",  c_last, 1);

    // Gappy input, 4 rows.
    in_valid = 1'b0; out_ready = 1'b1;
    start_tile(1'b0, 4);
    k = 0;
    while (c_done == 0 && k < 100) begin in_valid = (k % 3 == 0); cycle(); k++; end
    check("gap4_done",  c_done, 1);
    check("gap4_xfers", c_xfer, 4);

    // Gappy input, 10 rows: bubbles inserted while results leave mid-stream.
    in_valid = 1'b0;
    start_tile(1'b0, 10);
    k = 0;
    while (c_done == 0 && k < 100) begin in_valid = (k % 3 == 0); cycle(); k++; end
    check("gap10_done",    c_done, 1);
    check("gap10_xfers",   c_xfer, 10);
    check("gap10_bubbles", c_sbub, 4);

    // Reset in the middle of streaming.
    in_valid = 1'b1; out_ready = 1'b1;
    start_tile(1'b0, 6);
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_abort", {busy, out_valid, in_ready}, 3'b000);
    start_tile(1'b0, 2);
    wait_done(100, cyc);
    check("rst_retile_xfers", c_xfer, 2);

    // Start while busy is ignored; back-to-back start after done accepted.
    start_tile(1'b0, 5);
    cycle(); cycle();
    start = 1'b1; num_rows = RW'(9); load_weights = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(100, cyc);
    check("ignore_xfers", c_xfer, 5);
    check("ignore_last",  c_last, 1);
    w_valid = 1'b1;
    start_tile(1'b1, 2);
    check("b2b_busy", busy, 1'b1);
    wait_done(100, cyc);
    check("b2b_cycles", cyc, 15);
    check("b2b_xfers", c_xfer, 2);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 5000; t++) begin
      reset        = ($urandom_range(0, 599) == 0);
      start        = ($urandom_range(0, 3) == 0);
      load_weights = 1'($urandom_range(0, 1));
      num_rows     = RW'($urandom_range(0, 20));
      w_valid      = ($urandom_range(0, 9) < 7);
      in_valid     = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < 6);
      cycle();
    end
    reset = 1'b0; start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
